// File: rtl/fxp_conv_rr_sched.sv
// fxp_conv_rr_sched: round-robin sharing of one fp32->Q(WOI).(WOF) converter with a registered,
// id-tagged output stage and a saturating overflow counter.
module fxp_conv_rr_sched #(
  parameter int NREQ = 4,
  parameter int WOI  = 9,
  parameter int WOF  = 7,
  parameter int IDW  = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [32*NREQ-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  output logic               out_valid,
  output logic [15:0]        out_data,
  output logic [IDW-1:0]     out_id,
  output logic               out_ovf,
  input  logic               out_ready,
  input  logic               ovf_clr,
  output logic [15:0]        ovf_cnt,
  output logic               busy
);
  logic [IDW-1:0] ptr_q, ptr_d, id_q, id_d, win;
  logic           valid_q, valid_d, ovf_q, ovf_d, any, can_load, xfer, cov, czero;
  logic [15:0]    data_q, data_d, cnt_q, cnt_d, mag, res;
  logic [31:0]    w;
  logic [7:0]     e;
  logic [4:0]     rsh;
  always_comb begin
    any = 1'b0;
    win = '0;
    for (int k = 1; k <= NREQ; k++)
      if (!any && req_valid[(int'(ptr_q) + k) % NREQ]) begin
        any = 1'b1;
        win = IDW'((int'(ptr_q) + k) % NREQ);
      end
  end
  // |x| >= 2^(WOI-1) saturates (including -2^(WOI-1), inf and NaN); tiny values flush to zero
  always_comb begin
    w     = req_data[32*win +: 32];
    e     = w[30:23];
    cov   = e >= 8'(126 + WOI);
    czero = e < 8'(127 - WOF);
    rsh   = 5'(8'(150 - WOF) - e);
    mag   = 16'({1'b1, w[22:0]} >> rsh);
    res   = cov ? (w[31] ? 16'h8000 : 16'h7FFF) : czero ? 16'h0000 : (w[31] ? -mag : mag);
  end
  always_comb begin
    can_load  = !valid_q | out_ready;
    req_ready = (any & can_load & rst_n) ? NREQ'(1) << win : '0;
    xfer      = |req_ready;
    valid_d   = xfer | (valid_q & !out_ready);
    data_d    = xfer ? res : data_q;
    id_d      = xfer ? win : id_q;
    ovf_d     = xfer ? cov : ovf_q;
    ptr_d     = xfer ? win : ptr_q;
    cnt_d     = ovf_clr ? 16'h0000 : (xfer & cov & ~&cnt_q) ? cnt_q + 16'h1 : cnt_q;
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      id_q    <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
      ptr_q   <= IDW'(NREQ - 1);
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      id_q    <= id_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
    end
  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_id    = id_q;
  assign out_ovf   = ovf_q;
  assign ovf_cnt   = cnt_q;
  assign busy      = valid_q | (|req_valid);
endmodule
